// File: rtl/tdm_demux4_if.sv
// Bundle of the stream input and held-channel outputs of tdm_demux4.
// master: the side that drives the TDM stream (sequencer or bench).
// slave : the demultiplexer itself.
interface tdm_demux4_if #(
    parameter int W = 1
);
    logic [W-1:0] din;
    logic         din_valid;
    logic         frame_sync;
    logic [W-1:0] Y0;
    logic [W-1:0] Y1;
    logic [W-1:0] Y2;
    logic [W-1:0] Y3;
    logic [3:0]   ch_valid;
    logic         frame_done;
    logic         locked;
    logic         sync_err;

    modport master (
        output din, din_valid, frame_sync,
        input  Y0, Y1, Y2, Y3, ch_valid, frame_done, locked, sync_err
    );

    modport slave (
        input  din, din_valid, frame_sync,
        output Y0, Y1, Y2, Y3, ch_valid, frame_done, locked, sync_err
    );
endinterface

// File: rtl/tdm_demux4.sv
// tdm_demux4: 4-channel TDM receive demultiplexer.
// Aligns to the stream on frame_sync (marks channel 0), then steers each valid
// sample to Y0..Y3 in channel order 0,1,2,3 and holds it there.
// Optional build macro TDM_DEMUX_DBLBUF_EN: samples collect in shadow
// registers and Y0..Y3 update together when the channel-3 sample arrives.
module tdm_demux4 #(
    parameter int W = 1
) (
    input logic          clk,
    input logic          rst_n,
    tdm_demux4_if.slave  bus
);

    typedef enum logic {
        HUNT = 1'b0,
        LOCK = 1'b1
    } state_t;

    state_t       state, state_nxt;
    logic [1:0]   slot, slot_nxt;
    logic [3:0]   wr_sel;
    logic         done_nxt;
    logic         err_nxt;

    logic [W-1:0] y_q [4];
    logic [3:0]   ch_valid_q;
    logic         frame_done_q;
    logic         sync_err_q;

    // Next-state logic: decide which channel (if any) this beat addresses.
    // NOTE: every output of this block gets a default first so no path leaves
    // a signal unassigned, which would otherwise infer a latch.
    always_comb begin
        state_nxt = state;
        slot_nxt  = slot;
        wr_sel    = 4'b0000;
        done_nxt  = 1'b0;
        err_nxt   = 1'b0;
        if (bus.din_valid) begin
            unique case (state)
                HUNT: begin
                    if (bus.frame_sync) begin
                        wr_sel    = 4'b0001;
                        slot_nxt  = 2'd1;
                        state_nxt = LOCK;
                    end
                end
                LOCK: begin
                    if (bus.frame_sync && (slot != 2'd0)) begin
                        // Sync arrived mid-frame: restart the frame on this sample.
                        err_nxt  = 1'b1;
                        wr_sel   = 4'b0001;
                        slot_nxt = 2'd1;
                    end else begin
                        wr_sel   = 4'b0001 << slot;
                        slot_nxt = slot + 2'd1;
                        done_nxt = (slot == 2'd3);
                    end
                end
                default: ;
            endcase
        end
    end

    // State, slot counter and single-cycle status pulses.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= HUNT;
            slot         <= 2'd0;
            frame_done_q <= 1'b0;
            sync_err_q   <= 1'b0;
        end else begin
            state        <= state_nxt;
            slot         <= slot_nxt;
            frame_done_q <= done_nxt;
            sync_err_q   <= err_nxt;
        end
    end

`ifdef TDM_DEMUX_DBLBUF_EN
    logic [W-1:0] sh_q [3];

    // Collect channels 0..2 in shadows; publish the whole frame on channel 3.
    // NOTE: the small held-sample arrays are reset because reset must clear
    // Y0..Y3 and discard any partial frame.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < 3; k++) sh_q[k] <= '0;
            for (int k = 0; k < 4; k++) y_q[k]  <= '0;
            ch_valid_q <= 4'b0000;
        end else begin
            if (wr_sel[0]) sh_q[0] <= bus.din;
            if (wr_sel[1]) sh_q[1] <= bus.din;
            if (wr_sel[2]) sh_q[2] <= bus.din;
            if (err_nxt) begin
                sh_q[1] <= '0;
                sh_q[2] <= '0;
            end
            if (wr_sel[3]) begin
                y_q[0]     <= sh_q[0];
                y_q[1]     <= sh_q[1];
                y_q[2]     <= sh_q[2];
                y_q[3]     <= bus.din;
                ch_valid_q <= 4'b1111;
            end else begin
                ch_valid_q <= 4'b0000;
            end
        end
    end
`else
    // Write the addressed channel directly; unaddressed channels hold.
    // NOTE: the small held-sample arrays are reset because reset must clear
    // Y0..Y3 and discard any partial frame.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < 4; k++) y_q[k] <= '0;
            ch_valid_q <= 4'b0000;
        end else begin
            for (int k = 0; k < 4; k++) begin
                if (wr_sel[k]) y_q[k] <= bus.din;
            end
            ch_valid_q <= wr_sel;
        end
    end
`endif

    assign bus.Y0         = y_q[0];
    assign bus.Y1         = y_q[1];
    assign bus.Y2         = y_q[2];
    assign bus.Y3         = y_q[3];
    assign bus.ch_valid   = ch_valid_q;
    assign bus.frame_done = frame_done_q;
    assign bus.sync_err   = sync_err_q;
    assign bus.locked     = (state == LOCK);

endmodule

// File: tb/tb_tdm_demux4.sv
// Directed self-checking bench for tdm_demux4 with W=4.
// Expectations follow the per-sample build unless TDM_DEMUX_DBLBUF_EN is set.
module tb_tdm_demux4;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_errors;

    tdm_demux4_if #(.W(4)) bus ();

    tdm_demux4 #(.W(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Safety net so the run always ends.
    initial begin
        #200000;
        $display("FAIL timeout: run did not finish, got running, expected finished");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [3:0] got, input logic [3:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Present one valid beat, then check the pulses produced by that edge.
    task automatic send(input logic [3:0] d, input logic s, input logic [3:0] cv,
                        input logic done, input logic err);
        logic [3:0] cv_exp;
        @(negedge clk);
        bus.din        = d;
        bus.din_valid  = 1'b1;
        bus.frame_sync = s;
        @(posedge clk);
        #1;
`ifdef TDM_DEMUX_DBLBUF_EN
        cv_exp = done ? 4'hF : 4'h0;
`else
        cv_exp = cv;
`endif
        check($sformatf("ch_valid d=%h", d), bus.ch_valid, cv_exp);
        check($sformatf("frame_done d=%h", d), 4'(bus.frame_done), 4'(done));
        check($sformatf("sync_err d=%h", d), 4'(bus.sync_err), 4'(err));
    endtask

    // Idle cycles with din_valid low; frame_sync may be held high to show it is ignored.
    task automatic idle(input int n, input logic s);
        @(negedge clk);
        bus.din_valid  = 1'b0;
        bus.frame_sync = s;
        bus.din        = 4'hE;
        repeat (n) @(posedge clk);
        #1;
        check("ch_valid idle", bus.ch_valid, 4'h0);
        check("sync_err idle", 4'(bus.sync_err), 4'h0);
        bus.frame_sync = 1'b0;
    endtask

    task automatic check_y(input string tag, input logic [3:0] a, input logic [3:0] b,
                           input logic [3:0] c, input logic [3:0] d);
        check({tag, " Y0"}, bus.Y0, a);
        check({tag, " Y1"}, bus.Y1, b);
        check({tag, " Y2"}, bus.Y2, c);
        check({tag, " Y3"}, bus.Y3, d);
    endtask

    initial begin
        n_checks       = 0;
        n_errors       = 0;
        rst_n          = 1'b0;
        bus.din        = 4'h0;
        bus.din_valid  = 1'b0;
        bus.frame_sync = 1'b0;

        // Reset state.
        repeat (2) @(posedge clk);
        #1;
        check_y("reset", 4'h0, 4'h0, 4'h0, 4'h0);
        check("reset ch_valid", bus.ch_valid, 4'h0);
        check("reset locked", 4'(bus.locked), 4'h0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("locked after release", 4'(bus.locked), 4'h0);

        // Basic frame A,B,C,D.
        send(4'hA, 1'b1, 4'h1, 1'b0, 1'b0);
        check("locked after sync", 4'(bus.locked), 4'h1);
`ifdef TDM_DEMUX_DBLBUF_EN
        check("Y0 after A", bus.Y0, 4'h0);
`else
        check("Y0 after A", bus.Y0, 4'hA);
`endif
        send(4'hB, 1'b0, 4'h2, 1'b0, 1'b0);
        send(4'hC, 1'b0, 4'h4, 1'b0, 1'b0);
        send(4'hD, 1'b0, 4'h8, 1'b1, 1'b0);
        idle(1, 1'b0);
        check_y("frame ABCD", 4'hA, 4'hB, 4'hC, 4'hD);

        // Asynchronous reset mid-frame clears outputs without a clock edge.
        send(4'h1, 1'b1, 4'h1, 1'b0, 1'b0);
        send(4'h2, 1'b0, 4'h2, 1'b0, 1'b0);
        @(negedge clk);
        bus.din_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        check_y("async reset", 4'h0, 4'h0, 4'h0, 4'h0);
        check("async reset locked", 4'(bus.locked), 4'h0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("locked after mid reset", 4'(bus.locked), 4'h0);

        // HUNT discards samples before the first sync.
        send(4'h5, 1'b0, 4'h0, 1'b0, 1'b0);
        send(4'h6, 1'b0, 4'h0, 1'b0, 1'b0);
        check("locked in hunt", 4'(bus.locked), 4'h0);
        send(4'h1, 1'b1, 4'h1, 1'b0, 1'b0);
        send(4'h2, 1'b0, 4'h2, 1'b0, 1'b0);
        send(4'h3, 1'b0, 4'h4, 1'b0, 1'b0);
        send(4'h4, 1'b0, 4'h8, 1'b1, 1'b0);
        idle(1, 1'b0);
        check_y("hunt discard", 4'h1, 4'h2, 4'h3, 4'h4);

        // Gaps of 3 idle cycles with frame_sync high while invalid.
        send(4'hA, 1'b1, 4'h1, 1'b0, 1'b0);
        idle(3, 1'b1);
        send(4'hB, 1'b0, 4'h2, 1'b0, 1'b0);
        idle(3, 1'b1);
        send(4'hC, 1'b0, 4'h4, 1'b0, 1'b0);
        idle(3, 1'b1);
        send(4'hD, 1'b0, 4'h8, 1'b1, 1'b0);
        idle(3, 1'b1);
        check_y("gaps", 4'hA, 4'hB, 4'hC, 4'hD);

        // Misaligned sync on the third beat realigns to channel 0.
        send(4'h1, 1'b1, 4'h1, 1'b0, 1'b0);
        send(4'h2, 1'b0, 4'h2, 1'b0, 1'b0);
        send(4'h9, 1'b1, 4'h1, 1'b0, 1'b1);
        check("locked after realign", 4'(bus.locked), 4'h1);
`ifdef TDM_DEMUX_DBLBUF_EN
        check_y("realign held", 4'hA, 4'hB, 4'hC, 4'hD);
`else
        check("Y0 after realign", bus.Y0, 4'h9);
`endif
        send(4'h3, 1'b0, 4'h2, 1'b0, 1'b0);
`ifndef TDM_DEMUX_DBLBUF_EN
        check("Y1 after realign", bus.Y1, 4'h3);
`endif
        send(4'h4, 1'b0, 4'h4, 1'b0, 1'b0);
        send(4'h5, 1'b0, 4'h8, 1'b1, 1'b0);
        idle(1, 1'b0);
        check_y("realigned frame", 4'h9, 4'h3, 4'h4, 4'h5);

        // Back-to-back frames, sync on 1 and 5, no gap.
        send(4'h1, 1'b1, 4'h1, 1'b0, 1'b0);
        send(4'h2, 1'b0, 4'h2, 1'b0, 1'b0);
        send(4'h3, 1'b0, 4'h4, 1'b0, 1'b0);
`ifdef TDM_DEMUX_DBLBUF_EN
        check_y("b2b mid frame", 4'h9, 4'h3, 4'h4, 4'h5);
`else
        check_y("b2b mid frame", 4'h1, 4'h2, 4'h3, 4'h5);
`endif
        send(4'h4, 1'b0, 4'h8, 1'b1, 1'b0);
        check_y("b2b frame 1", 4'h1, 4'h2, 4'h3, 4'h4);
        send(4'h5, 1'b1, 4'h1, 1'b0, 1'b0);
        send(4'h6, 1'b0, 4'h2, 1'b0, 1'b0);
        send(4'h7, 1'b0, 4'h4, 1'b0, 1'b0);
        send(4'h8, 1'b0, 4'h8, 1'b1, 1'b0);
        idle(1, 1'b0);
        check_y("b2b frame 2", 4'h5, 4'h6, 4'h7, 4'h8);
        check("locked at end", 4'(bus.locked), 4'h1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
